mean_sq_q248: RTL and testbench

//   Streaming mean-square stage in the Q24.8 RMS path. Accepts signed Q24.8 samples

---
 rtl/mean_sq_q248.sv | 103 ++++++++++
 tb/tb_mean_sq_q248.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mean_sq_q248.sv
// mean_sq_q248
//   Streaming mean-square stage of the Q24.8 RMS path. Squares signed Q24.8
//   samples, accumulates 2**LOG2N squares and presents their truncated
//   unsigned Q24.8 mean, which is the radicand for the square-root stage.
// Parameters
//   LOG2N      log2 of samples per frame (1..8)
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort (drops partial sum and pending result)
//   in_valid   sample valid
//   in_ready   stage can accept a sample (registered state decode)
//   in_data    signed Q24.8 sample
//   out_valid  mean-square result valid
//   out_ready  downstream accepts result
//   out_data   unsigned Q24.8 mean of squares
module mean_sq_q248 #(
   parameter int unsigned LOG2N = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [LOG2N-1:0] CNT_ONE = 1;

   state_t             state;
   state_t             state_nx;
   logic [31:0]        mag;
   logic [63:0]        sq64;
   logic [31:0]        sq;
   logic [LOG2N+31:0]  acc;
   logic [LOG2N+31:0]  sum;
   logic [LOG2N-1:0]   count;
   logic               accept;
   logic               last;
   logic               unused_lsb;

   // Two's-complement negate maps 0x8000_0000 onto itself, which read as
   // unsigned is exactly 2**31, so no special case is needed.
   assign mag  = in_data[31] ? (~in_data + 32'd1) : in_data;
   assign sq64 = {32'd0, mag} * {32'd0, mag};
   // Q48.16 product: drop 8 fraction bits; anything above bit 39 saturates.
   assign sq   = (|sq64[63:40]) ? '1 : sq64[39:8];
   assign unused_lsb = ^sq64[7:0];

   assign sum    = acc + {{LOG2N{1'b0}}, sq};
   assign last   = (count == '1);
   assign accept = in_valid && in_ready;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (accept && last) state_nx = HOLD;
            HOLD:    if (out_ready)      state_nx = ACCUM;
            default: state_nx = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         count    <= '0;
         out_data <= '0;
      end else if (clear) begin
         acc   <= '0;
         count <= '0;
      end else if (accept) begin
         if (last) begin
            out_data <= sum[LOG2N+31:LOG2N];
            acc      <= '0;
            count    <= '0;
         end else begin
            acc   <= sum;
            count <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_mean_sq_q248.sv
// tb_mean_sq_q248
//   Directed bench for mean_sq_q248 with LOG2N=2 (frames of 4 samples).
module tb_mean_sq_q248;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int unsigned errors = 0;
   int unsigned checks = 0;

   mean_sq_q248 #(.LOG2N(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sends one sample; in_ready must already be high so it is accepted at the edge.
   task automatic send(input string tag, input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Four samples; checks result latency and value, then leaves stage in HOLD.
   task automatic frame(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] exp);
      send(tag, d0);
      send(tag, d1);
      send(tag, d2);
      check({tag, ".early_valid"}, {31'd0, out_valid}, 32'd0);
      send(tag, d3);
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".in_ready_hold"}, {31'd0, in_ready}, 32'd0);
      check({tag, ".out_data"}, out_data, exp);
   endtask

   task automatic deliver(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      tick();
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.out_data", out_data, 32'd0);
      #3 rst_n = 1'b1;
      tick();

      // +-2.0 -> 4.0
      frame("t1", 32'h0000_0200, 32'hFFFF_FE00, 32'h0000_0200, 32'hFFFF_FE00, 32'h0000_0400);
      deliver("t1");

      // 1,2,3,4 -> squares sum 30.0, mean 7.5
      frame("t2", 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 32'h0000_0780);
      deliver("t2");

      // saturating squares
      frame("t3", 32'h7FFF_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000, 32'hFFFF_FFFF);
      deliver("t3");

      // tiny squares truncate to 0,0,0,1 -> mean 0
      frame("t4", 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0008, 32'h0000_0010, 32'h0000_0000);

      // back-pressure in HOLD: offered samples must not be consumed
      in_valid = 1'b1;
      in_data  = 32'h7FFF_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5.in_ready", {31'd0, in_ready}, 32'd0);
         check("t5.out_valid", {31'd0, out_valid}, 32'd1);
         check("t5.out_data", out_data, 32'h0000_0000);
      end
      in_valid = 1'b0;
      deliver("t5");
      frame("t5n", 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 32'h0000_0780);
      deliver("t5n");

      // clear mid-frame, coinciding with a sample that must be dropped
      send("t6a", 32'h0000_1000);
      send("t6a", 32'h0000_1000);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h0000_1000;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t6.clear_ready", {31'd0, in_ready}, 32'd1);
      frame("t6b", 32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100);

      // clear together with out_ready in HOLD: result dropped, back to ACCUM
      clear     = 1'b1;
      out_ready = 1'b1;
      tick();
      clear     = 1'b0;
      out_ready = 1'b0;
      check("t6.clear_hold_valid", {31'd0, out_valid}, 32'd0);

      // asynchronous reset while holding a result
      frame("t6c", 32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 32'h0000_0400);
      rst_n = 1'b0;
      #1;
      check("t6.arst_valid", {31'd0, out_valid}, 32'd0);
      check("t6.arst_data", out_data, 32'd0);
      check("t6.arst_ready", {31'd0, in_ready}, 32'd1);
      #3 rst_n = 1'b1;
      tick();
      frame("t6d", 32'h0000_0200, 32'hFFFF_FE00, 32'h0000_0200, 32'hFFFF_FE00, 32'h0000_0400);
      deliver("t6d");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
